// File: rtl/ram_system_pkg.sv
// Shared constants and the active-low seven-segment font for the ram_system lab block.
package ram_system_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned DEPTH  = 32;

  // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
  function automatic logic [6:0] seg7_font(input logic [3:0] v);
    logic [6:0] s;
    s = '1;
    unique case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ram_system_display.sv
// Registers addr/wr_data to line up with the RAM read register, then decodes four HEX digits.
module RAMDisplay
  import ram_system_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data,
  output logic [6:0]        addrHEX1,
  output logic [6:0]        addrHEX0,
  output logic [6:0]        wrHEX,
  output logic [6:0]        reHEX
);

  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_r;
  logic [3:0]        addr_hi;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_r <= '0;
      data_r <= '0;
    end else begin
      addr_r <= addr;
      data_r <= wr_data;
    end
  end

  assign addr_hi = {3'b000, addr_r[4]};

  seg7_decode u_addr_hi (.digit(addr_hi),     .seg(addrHEX1));
  seg7_decode u_addr_lo (.digit(addr_r[3:0]), .seg(addrHEX0));
  seg7_decode u_wr      (.digit(data_r),      .seg(wrHEX));
  seg7_decode u_rd      (.digit(rd_data),     .seg(reHEX));

endmodule

// File: rtl/ram_system_ram.sv
// 32x4 flop-based RAM with registered, read-before-write output; reset clears every word.
module RAM
  import ram_system_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  // q samples the old word before the write lands, so a write shows one edge later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem <= '{default: '0};
      q   <= '0;
    end else begin
      q <= mem[addr];
      if (wr_en) mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/ram_system_seg7.sv
// Combinational hex-digit to active-low seven-segment decoder.
module seg7_decode
  import ram_system_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = seg7_font(digit);
  end

endmodule

// File: rtl/ram_system.sv
// Board-level RAM lab block: RAM core plus registered HEX display front end.
module ram_system
  import ram_system_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [6:0]        addrHEX1,
  output logic [6:0]        addrHEX0,
  output logic [6:0]        wrHEX,
  output logic [6:0]        reHEX
);

  logic [DATA_W-1:0] q;

  RAM u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .addr    (addr),
    .wr_data (wr_data),
    .q       (q)
  );

  RAMDisplay u_disp (
    .clk      (clk),
    .reset_n  (reset_n),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (q),
    .addrHEX1 (addrHEX1),
    .addrHEX0 (addrHEX0),
    .wrHEX    (wrHEX),
    .reHEX    (reHEX)
  );

endmodule

// File: tb/tb_ram_system.sv
// Randomized and directed self-checking bench for ram_system against a word-array reference model.
module tb_ram_system;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic [4:0] addr;
  logic [3:0] wr_data;
  logic [6:0] addrHEX1, addrHEX0, wrHEX, reHEX;

  ram_system dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .addr     (addr),
    .wr_data  (wr_data),
    .addrHEX1 (addrHEX1),
    .addrHEX0 (addrHEX0),
    .wrHEX    (wrHEX),
    .reHEX    (reHEX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] font [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference model: word contents plus what each digit should currently show.
  int unsigned mem_m [32];
  int unsigned q_m, a_m, d_m;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".addrHEX1"}, addrHEX1, font[a_m / 16]);
    check({tag, ".addrHEX0"}, addrHEX0, font[a_m % 16]);
    check({tag, ".wrHEX"},    wrHEX,    font[d_m]);
    check({tag, ".reHEX"},    reHEX,    font[q_m]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem_m[i] = 0;
    q_m = 0; a_m = 0; d_m = 0;
  endtask

  // One clock: drive, advance, update model, optionally compare.
  task automatic step(input bit we, input int unsigned a, input int unsigned d,
                      input string tag, input bit do_check);
    wr_en   = we;
    addr    = a[4:0];
    wr_data = d[3:0];
    @(posedge clk);
    q_m = mem_m[a];
    if (we) mem_m[a] = d;
    a_m = a;
    d_m = d;
    #1;
    if (do_check) check_all(tag);
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en   = 1'b0;
    addr    = '0;
    wr_data = '0;
    model_reset();
    #1;
    check_all("reset_hold");
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_hold2");
    reset_n = 1'b1;

    // Write then read back at address 0
    step(1, 0, 1, "wr0_e1", 1);
    check("wr0_e1_old", reHEX, 7'b1000000);
    step(1, 0, 1, "wr0_e2", 1);
    check("wr0_e2_new", reHEX, 7'b1111001);
    check("wr0_wrhex", wrHEX, 7'b1111001);

    // Write disabled
    step(0, 1, 8, "nowr_e1", 1);
    step(0, 1, 8, "nowr_e2", 1);
    check("nowr_re", reHEX, 7'b1000000);
    check("nowr_wr", wrHEX, 7'b0000000);
    step(0, 0, 8, "nowr_rd0", 1);
    check("nowr_kept", reHEX, 7'b1111001);

    // Overwrite address 0
    step(1, 0, 8, "ovw_e1", 1);
    check("ovw_old", reHEX, 7'b1111001);
    step(1, 0, 8, "ovw_e2", 1);
    step(1, 0, 8, "ovw_e3", 1);
    check("ovw_new", reHEX, 7'b0000000);

    // Address sweep
    for (int i = 0; i < 32; i++) step(1, i, i % 16, "sweep_wr", 1);
    for (int i = 0; i < 32; i++) begin
      step(0, i, $urandom_range(0, 15), "sweep_rd", 1);
      check("sweep_hi", addrHEX1, (i < 16) ? 7'b1000000 : 7'b1111001);
    end
    step(0, 0, 0, "wrap_0", 1);

    // Write-data display tracking with writes off
    for (int v = 0; v < 16; v++) step(0, 5, v, "wdisp", 1);

    // Randomized traffic
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 31), $urandom_range(0, 15), "rand", 1);

    // Asynchronous reset mid-run, held across a write edge
    #2;
    reset_n = 1'b0;
    wr_en   = 1'b1;
    addr    = 5'd3;
    wr_data = 4'hF;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_over_wr");
    reset_n = 1'b1;
    for (int i = 0; i < 32; i++) step(0, i, 0, "post_rst", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
